// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: word and window sizes, small-sigma rotate/shift
// amounts, and the message-schedule FSM state encoding.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int WIN_DEPTH  = 16;
   localparam int ROUNDS_MAX = 64;
   localparam int T_W        = $clog2(ROUNDS_MAX);

   localparam int S0_R1 = 7;
   localparam int S0_R2 = 18;
   localparam int S0_SH = 3;
   localparam int S1_R1 = 17;
   localparam int S1_R2 = 19;
   localparam int S1_SH = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rotr.sv
// Combinational rotate-right of a W-bit word by a fixed amount AMT (0 < AMT < W).
module rotr #(
   parameter int W   = 32,
   parameter int AMT = 1
) (
   input  logic [W-1:0] x_i,
   output logic [W-1:0] y_o
);

   assign y_o = (x_i >> AMT) | (x_i << (W - AMT));

endmodule

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: rotr(R1) ^ rotr(R2) ^ shr(SH); purely combinational.
module sha256_small_sigma
   import sha256_pkg::*;
#(
   parameter int R1 = S0_R1,
   parameter int R2 = S0_R2,
   parameter int SH = S0_SH
) (
   input  logic [WORD_W-1:0] x_i,
   output logic [WORD_W-1:0] y_o
);

   logic [WORD_W-1:0] rot1;
   logic [WORD_W-1:0] rot2;

   rotr #(.W(WORD_W), .AMT(R1)) u_rot1 (.x_i(x_i), .y_o(rot1));
   rotr #(.W(WORD_W), .AMT(R2)) u_rot2 (.x_i(x_i), .y_o(rot2));

   assign y_o = rot1 ^ rot2 ^ (x_i >> SH);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads one 512-bit block, streams W[0..ROUNDS-1].
// Optional MSG_SCHED_ROUND_IDX_EN adds the wIdx round-index output.
module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        blkValid,
   output logic                        blkReady,
   input  logic [WIN_DEPTH*WORD_W-1:0] blkData,
   output logic                        wValid,
   input  logic                        wReady,
   output logic [WORD_W-1:0]           wData,
   output logic                        wLast
`ifdef MSG_SCHED_ROUND_IDX_EN
   ,
   output logic [T_W-1:0]              wIdx
`endif
);

   state_t            state_q, state_d;
   logic [T_W-1:0]    t_q, t_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [WORD_W-1:0] win_q [WIN_DEPTH];
   logic [WORD_W-1:0] win_d [WIN_DEPTH];

   logic [WORD_W-1:0] s0_y;
   logic [WORD_W-1:0] s1_y;
   logic [WORD_W-1:0] nxt;
   logic              beat;
   logic              final_t;

   sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (
      .x_i (win_q[1]),
      .y_o (s0_y)
   );

   sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (
      .x_i (win_q[14]),
      .y_o (s1_y)
   );

   // W[t+16] from the registered window; overflow beyond 32 bits is dropped.
   assign nxt     = s1_y + win_q[9] + s0_y + win_q[0];
   assign beat    = valid_q & wReady;
   assign final_t = (t_q == T_W'(ROUNDS - 1));

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      valid_d = valid_q;
      last_d  = last_q;
      for (int i = 0; i < WIN_DEPTH; i++) begin
         win_d[i] = win_q[i];
      end

      case (state_q)
         IDLE: begin
            if (blkValid) begin
               for (int i = 0; i < WIN_DEPTH; i++) begin
                  win_d[i] = blkData[(WIN_DEPTH-1-i)*WORD_W +: WORD_W];
               end
               t_d     = '0;
               valid_d = 1'b1;
               last_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (beat) begin
               for (int i = 0; i < WIN_DEPTH-1; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[WIN_DEPTH-1] = nxt;
               t_d = t_q + T_W'(1);
               if (final_t) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  // Flag goes up one beat early so wLast is a plain register.
                  last_d = (t_q == T_W'(ROUNDS - 2));
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   assign blkReady = (state_q == IDLE);
   assign wValid   = valid_q;
   assign wLast    = last_q;
   assign wData    = win_q[0];

`ifdef MSG_SCHED_ROUND_IDX_EN
   assign wIdx = t_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule; also covers wIdx when built with MSG_SCHED_ROUND_IDX_EN.
module tb_sha256_msg_schedule;

   localparam int ROUNDS = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         blkValid;
   logic         blkReady;
   logic [511:0] blkData;
   logic         wValid;
   logic         wReady;
   logic [31:0]  wData;
   logic         wLast;
`ifdef MSG_SCHED_ROUND_IDX_EN
   logic [5:0]   wIdx;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0]  exp_w [64];
   logic [511:0] abc_blk;
   logic [511:0] zero_blk;
   logic [511:0] b_blk;
   int           cyc;

   always #5 clk = ~clk;

   sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .blkValid (blkValid),
      .blkReady (blkReady),
      .blkData  (blkData),
      .wValid   (wValid),
      .wReady   (wReady),
      .wData    (wData),
      .wLast    (wLast)
`ifdef MSG_SCHED_ROUND_IDX_EN
      ,
      .wIdx     (wIdx)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] rot(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rot(x, 7) ^ rot(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rot(x, 17) ^ rot(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_exp(input logic [511:0] b);
      for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
   endtask

   task automatic send_block(input logic [511:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!blkReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!blkReady) chk("blkready_timeout", 32'(blkReady), 32'd1);
      blkData  = b;
      blkValid = 1'b1;
      @(posedge clk);
      #1 blkValid = 1'b0;
   endtask

   // Walks the beats of one block, checking every cycle the word is presented.
   task automatic stream(input string tag, input int stall_at, input int stall_len,
                         input int abort_at, output int cycles);
      int beat;
      int stalled;
      beat    = 0;
      stalled = 0;
      cycles  = 0;
      while (beat < ROUNDS) begin
         @(negedge clk);
         cycles++;
         if (cycles > ROUNDS + stall_len + 10) begin
            chk({tag, "_timeout"}, 32'(beat), 32'(ROUNDS));
            return;
         end
         chk({tag, "_wvalid"}, 32'(wValid), 32'd1);
         chk({tag, "_wdata"}, wData, exp_w[beat]);
         chk({tag, "_wlast"}, 32'(wLast), 32'(beat == ROUNDS-1));
`ifdef MSG_SCHED_ROUND_IDX_EN
         chk({tag, "_widx"}, 32'(wIdx), 32'(beat));
`endif
         if (beat == abort_at) return;
         if (beat == stall_at && stalled < stall_len) begin
            wReady = 1'b0;
            stalled++;
         end else begin
            wReady = 1'b1;
         end
         if (wValid && wReady) beat++;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      blkValid = 1'b0;
      blkData  = '0;
      wReady   = 1'b1;
      abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
      zero_blk = '0;
      for (int i = 0; i < 16; i++) b_blk[511-32*i -: 32] = 32'h01234567 ^ (32'(i) * 32'h11111111);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_blkready", 32'(blkReady), 32'd1);
      chk("rst_wvalid", 32'(wValid), 32'd0);
      chk("rst_wlast", 32'(wLast), 32'd0);
      chk("rst_wdata", wData, 32'd0);
      rst_n = 1'b1;

      // Test 1: "abc" block, model anchored to known schedule words
      build_exp(abc_blk);
      chk("abc_w0", exp_w[0], 32'h61626380);
      chk("abc_w15", exp_w[15], 32'h00000018);
      chk("abc_w16", exp_w[16], 32'h61626380);
      chk("abc_w17", exp_w[17], 32'h000F0000);
      chk("abc_w18", exp_w[18], 32'h7DA86405);
      send_block(abc_blk);
      stream("t1", -1, 0, -1, cyc);
      chk("t1_cycles", 32'(cyc), 32'(ROUNDS));

      // Test 2: all-zero block, blkReady returns right after the last beat
      build_exp(zero_blk);
      send_block(zero_blk);
      stream("t2", -1, 0, -1, cyc);
      @(negedge clk);
      chk("t2_blkready_after", 32'(blkReady), 32'd1);
      chk("t2_wvalid_after", 32'(wValid), 32'd0);

      // Test 3: backpressure for 5 cycles at t=20
      build_exp(abc_blk);
      send_block(abc_blk);
      stream("t3", 20, 5, -1, cyc);
      chk("t3_cycles", 32'(cyc), 32'(ROUNDS + 5));

      // Test 4: blkValid held through RUN with another block
      build_exp(abc_blk);
      @(negedge clk);
      blkData  = abc_blk;
      blkValid = 1'b1;
      @(posedge clk);
      #1 blkData = b_blk;
      stream("t4a", -1, 0, -1, cyc);
      @(negedge clk);
      chk("t4_idle_blkready", 32'(blkReady), 32'd1);
      chk("t4_idle_wvalid", 32'(wValid), 32'd0);
      build_exp(b_blk);
      @(negedge clk);
      chk("t4_b_wvalid", 32'(wValid), 32'd1);
      chk("t4_b_blkready", 32'(blkReady), 32'd0);
      chk("t4_b_w0", wData, exp_w[0]);
      wReady   = 1'b0;
      blkValid = 1'b0;
      stream("t4b", -1, 0, -1, cyc);

      // Test 5: asynchronous reset mid-block, then a clean rerun
      build_exp(abc_blk);
      send_block(abc_blk);
      stream("t5a", -1, 0, 30, cyc);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_wvalid", 32'(wValid), 32'd0);
      chk("t5_rst_blkready", 32'(blkReady), 32'd1);
      chk("t5_rst_wlast", 32'(wLast), 32'd0);
      chk("t5_rst_wdata", wData, 32'd0);
      #2 rst_n = 1'b1;
      wReady = 1'b1;
      send_block(abc_blk);
      stream("t5b", -1, 0, -1, cyc);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
